load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes ALU_OUT as the effective address for RV32I loads and stores.
- Drives a single-outstanding request/grant/response data-memory bus and stalls the pipeline while an access is in flight.
- Performs byte-lane steering and byte-enable generation for stores; performs lane extraction and sign/zero extension for loads.

Parameters:
- DATA_WIDTH, 32, data and address width (`DATA_WIDTH` from sabit_veriler.vh); only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- lsu_valid_i  input  1  memory instruction present in this stage.
- lsu_we_i  input  1  1 = store, 0 = load.
- lsu_funct3_i  input  3  RV32I funct3 size/sign code.
- lsu_addr_i  input  32  effective address (ALU_OUT).
- lsu_wdata_i  input  32  store data (rs2).
- lsu_stall_o  output  1  hold upstream pipeline (combinational).
- lsu_done_o  output  1  one-cycle completion pulse.
- lsu_rdata_o  output  32  extended load result, valid while lsu_done_o is high.
- lsu_misalign_o  output  1  misaligned-access pulse, coincident with lsu_done_o.
- mem_req_o  output  1  bus request.
- mem_we_o  output  1  bus write.
- mem_addr_o  output  32  word-aligned address {addr[31:2], 2'b00}.
- mem_wdata_o  output  32  lane-replicated store data.
- mem_be_o  output  4  byte enables.
- mem_gnt_i  input  1  request accepted.
- mem_rvalid_i  input  1  response valid; asserted for both loads and stores.
- mem_rdata_i  input  32  read data.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0.
- States: IDLE, REQ, RESP.
- IDLE:
  - Accepts a request when lsu_valid_i=1 and lsu_done_o=0. lsu_valid_i is ignored in the done cycle because it still belongs to the retiring instruction.
  - On accept: latch we, funct3, addr, wdata; go to REQ.
- REQ:
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o held stable.
  - Stays in REQ until mem_gnt_i=1, then goes to RESP.
  - mem_rvalid_i is ignored in REQ.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i=1: register the load result (stores give 0), assert lsu_done_o for the next cycle, return to IDLE.
- lsu_stall_o = (state!=IDLE) | (state==IDLE & lsu_valid_i & ~lsu_done_o).
- Latency: minimum 3 cycles from accept to lsu_done_o (gnt and rvalid each in their first eligible cycle). Each wait cycle of gnt or rvalid adds one cycle.
- Store steering:
  - SB (000): be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH (001): be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW (010): be = 4'b1111.
- Load extraction:
  - Lane = mem_rdata_i >> (8*addr[1:0]) for byte loads, >> (16*addr[1]) for halfword loads.
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes through.
  - For loads, mem_be_o follows the same pattern as the equivalent store size.
- Unsupported funct3 values are treated as word access.
- mem_rvalid_i outside RESP is ignored, including stale responses after reset.
- Reset mid-operation: the access is abandoned, mem_req_o is 0 from the reset edge, and no lsu_done_o is produced.
- lsu_rdata_o holds its value outside the done cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
- With the macro:
  - A misaligned accepted request issues no bus transaction.
  - The unit goes IDLE -> IDLE, with lsu_done_o=1 and lsu_misalign_o=1 the cycle after accept.
  - lsu_rdata_o=0 in that cycle.
- Without the macro:
  - lsu_misalign_o is tied 0.
  - Offending low address bits are ignored: a halfword uses addr[1] only; a word uses a forced-aligned address.
  - A normal bus transaction occurs.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt and rvalid immediate -> mem_addr_o=0x100, be=1111, wdata=0xDEADBEEF; lsu_done_o exactly 3 cycles after accept; lsu_stall_o high until then.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata_o=0xA5A5A5A5, mem_addr_o=0x100.
- LB addr=0x202, rdata=0x12F05678 -> lsu_rdata_o=0xFFFFFFF0; same access as LBU -> 0x000000F0; LHU addr=0x202 -> 0x000012F0.
- LW with gnt delayed 3 cycles and rvalid delayed 2 -> request signals stable throughout REQ; lsu_done_o exactly 7 cycles after accept; no second request issued while lsu_valid_i stays high in the done cycle.
- rst asserted in RESP, then a stale rvalid -> lsu_done_o stays 0, all outputs 0, and the next request is accepted normally.
- LW addr=0x102 with LSU_MISALIGN_TRAP_EN -> mem_req_o never set; lsu_done_o=lsu_misalign_o=1 one cycle after accept. Without the macro -> bus access at 0x100 with be=1111.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage driving a single-outstanding req/gnt/rvalid data bus.
// Latency: 3 cycles from accept to lsu_done_o minimum, plus 1 per gnt or rvalid wait cycle.
// Backpressure: lsu_stall_o holds upstream from accept until the done cycle; the bus request is held stable until gnt.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses finish in 1 cycle with lsu_misalign_o and no bus access.
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_stall_o,
  output logic                  lsu_done_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_misalign_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Access size from funct3; LBU/LHU codes are loads only, so a store with them falls back to word.
  function automatic size_e decode_size(input logic we, input logic [2:0] f3);
    size_e sz;
    case (f3)
      3'b000:  sz = SZ_BYTE;
      3'b001:  sz = SZ_HALF;
      3'b100:  sz = we ? SZ_WORD : SZ_BYTE;
      3'b101:  sz = we ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  size_e                 req_size;
  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  accept;
  logic                  trap_now;

  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_data;

  // The done cycle still carries the retiring instruction, so lsu_valid_i is not a new request then.
  assign accept = (state_q == S_IDLE) && lsu_valid_i && !done_q;

  // Byte-lane steering and byte enables for the incoming request; loads use the same enable pattern.
  always_comb begin
    req_size  = decode_size(lsu_we_i, lsu_funct3_i);
    req_be    = 4'b1111;
    req_wdata = lsu_wdata_i;
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << lsu_addr_i[1:0];
        req_wdata = {4{lsu_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        req_wdata = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = lsu_wdata_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic req_misalign;

  // Halfword on an odd address or word not on a 4-byte boundary never reaches the bus.
  always_comb begin
    req_misalign = ((req_size == SZ_HALF) && lsu_addr_i[0]) ||
                   ((req_size == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00));
  end

  assign trap_now       = accept && req_misalign;
  assign lsu_misalign_o = misalign_q;
`else
  // Misaligned low bits are simply dropped: halfwords use addr[1], words use the aligned word.
  assign trap_now       = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  // Extract the addressed lane from the response word and extend it per the latched funct3.
  always_comb begin
    case (addr_lo_q)
      2'd0:    byte_lane = mem_rdata_i[7:0];
      2'd1:    byte_lane = mem_rdata_i[15:8];
      2'd2:    byte_lane = mem_rdata_i[23:16];
      default: byte_lane = mem_rdata_i[31:24];
    endcase
    half_lane = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Next-state logic: accept and latch in IDLE, wait for gnt in REQ, capture the response in RESP.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (trap_now) begin
          done_d     = 1'b1;
          rdata_d    = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          misalign_d = 1'b1;
`endif
        end else if (accept) begin
          we_d        = lsu_we_i;
          funct3_d    = lsu_funct3_i;
          addr_lo_d   = lsu_addr_i[1:0];
          mem_addr_d  = {lsu_addr_i[DATA_WIDTH-1:2], 2'b00};
          mem_wdata_d = req_wdata;
          mem_be_d    = req_be;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // Any rvalid here belongs to nobody and is dropped.
        if (mem_gnt_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          rdata_d = we_q ? '0 : load_data;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign lsu_stall_o = (state_q != S_IDLE) || accept;
  assign lsu_done_o  = done_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, bus wait states, reset mid-access, misalignment.
// Bus responses are scripted per access; expected values are hand-computed constants.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'b000;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_wdata_i = 32'h0;
  logic        lsu_stall_o;
  logic        lsu_done_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_funct3_i   (lsu_funct3_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_misalign_o (lsu_misalign_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_be_o       (mem_be_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: gw cycles without gnt, then rw cycles without rvalid after the grant.
  // lsu_valid_i stays high through the done cycle, as a stalled pipeline would hold it.
  task automatic access(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gw, input int rw, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                        input int exp_lat);
    int cyc;
    cyc = 0;
    lsu_valid_i  = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wd;
    #1;
    chk({nm, ".stall_acc"}, {31'b0, lsu_stall_o}, 32'd1);
    tick();
    cyc++;
    for (int w = 0; w <= gw; w++) begin
      mem_gnt_i    = (w == gw);
      mem_rvalid_i = (w != gw);
      mem_rdata_i  = 32'hBAD0BAD0;
      #1;
      chk({nm, ".req"},   {31'b0, mem_req_o},  32'd1);
      chk({nm, ".we"},    {31'b0, mem_we_o},   {31'b0, we});
      chk({nm, ".addr"},  mem_addr_o,          exp_addr);
      chk({nm, ".be"},    {28'b0, mem_be_o},   {28'b0, exp_be});
      chk({nm, ".wdata"}, mem_wdata_o,         exp_wd);
      chk({nm, ".stall"}, {31'b0, lsu_stall_o}, 32'd1);
      tick();
      cyc++;
    end
    for (int w = 0; w <= rw; w++) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = (w == rw);
      mem_rdata_i  = (w == rw) ? rd : 32'hBAD0BAD0;
      #1;
      chk({nm, ".req_resp"}, {31'b0, mem_req_o},   32'd0);
      chk({nm, ".done_early"}, {31'b0, lsu_done_o}, 32'd0);
      tick();
      cyc++;
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    #1;
    while (lsu_done_o !== 1'b1 && cyc < exp_lat + 4) begin
      tick();
      cyc++;
    end
    chk({nm, ".latency"},  cyc,                      exp_lat);
    chk({nm, ".done"},     {31'b0, lsu_done_o},      32'd1);
    chk({nm, ".rdata"},    lsu_rdata_o,              exp_rd);
    chk({nm, ".misalign"}, {31'b0, lsu_misalign_o},  32'd0);
    chk({nm, ".stall_done"}, {31'b0, lsu_stall_o},   32'd0);
    lsu_valid_i = 1'b0;
    tick();
    chk({nm, ".done_clr"},  {31'b0, lsu_done_o},     32'd0);
    chk({nm, ".no_req2"},   {31'b0, mem_req_o},      32'd0);
    chk({nm, ".rdata_hold"}, lsu_rdata_o,            exp_rd);
    tick();
  endtask

  initial begin
    // Reset with a stale response on the bus.
    rst = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55555555;
    tick();
    tick();
    chk("rst.req",   {31'b0, mem_req_o},   32'd0);
    chk("rst.done",  {31'b0, lsu_done_o},  32'd0);
    chk("rst.stall", {31'b0, lsu_stall_o}, 32'd0);
    chk("rst.rdata", lsu_rdata_o,          32'd0);
    chk("rst.be",    {28'b0, mem_be_o},    32'd0);
    chk("rst.addr",  mem_addr_o,           32'd0);
    rst = 1'b0;
    tick();
    chk("rst.stale_rvalid", {31'b0, lsu_done_o}, 32'd0);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    tick();

    //     name     we    f3      addr          wdata         gw rw rdata         exp_addr      be      exp_wdata     exp_rdata     lat
    access("sw",    1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 0, 0, 32'h0,        32'h00000100, 4'hF, 32'hDEADBEEF, 32'h0,        3);
    access("sb",    1'b1, 3'b000, 32'h00000103, 32'h000000A5, 0, 0, 32'h0,        32'h00000100, 4'h8, 32'hA5A5A5A5, 32'h0,        3);
    access("lb",    1'b0, 3'b000, 32'h00000202, 32'h0,        0, 0, 32'h12F05678, 32'h00000200, 4'h4, 32'h0,        32'hFFFFFFF0, 3);
    access("lbu",   1'b0, 3'b100, 32'h00000202, 32'h0,        0, 0, 32'h12F05678, 32'h00000200, 4'h4, 32'h0,        32'h000000F0, 3);
    access("lhu",   1'b0, 3'b101, 32'h00000202, 32'h0,        0, 0, 32'h12F05678, 32'h00000200, 4'hC, 32'h0,        32'h000012F0, 3);
    access("lh",    1'b0, 3'b001, 32'h00000200, 32'h0,        0, 0, 32'h12F08765, 32'h00000200, 4'h3, 32'h0,        32'hFFFF8765, 3);
    access("sh",    1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 0, 0, 32'h0,        32'h00000100, 4'hC, 32'hABCDABCD, 32'h0,        3);
    // gnt three cycles late; rvalid two cycles after the grant (one wait cycle).
    access("lw_slow", 1'b0, 3'b010, 32'h00000400, 32'h0,      3, 1, 32'hCAFEF00D, 32'h00000400, 4'hF, 32'h0,        32'hCAFEF00D, 7);

    // Reset while waiting for the response, then a stale rvalid.
    lsu_valid_i  = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'b010;
    lsu_addr_i   = 32'h00000300;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #1;
    chk("midrst.in_resp_req",   {31'b0, mem_req_o},   32'd0);
    chk("midrst.in_resp_stall", {31'b0, lsu_stall_o}, 32'd1);
    rst = 1'b1;
    lsu_valid_i = 1'b0;
    tick();
    chk("midrst.req",   {31'b0, mem_req_o},   32'd0);
    chk("midrst.we",    {31'b0, mem_we_o},    32'd0);
    chk("midrst.addr",  mem_addr_o,           32'd0);
    chk("midrst.wdata", mem_wdata_o,          32'd0);
    chk("midrst.be",    {28'b0, mem_be_o},    32'd0);
    chk("midrst.done",  {31'b0, lsu_done_o},  32'd0);
    chk("midrst.rdata", lsu_rdata_o,          32'd0);
    chk("midrst.stall", {31'b0, lsu_stall_o}, 32'd0);
    chk("midrst.mis",   {31'b0, lsu_misalign_o}, 32'd0);
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFFFFFF;
    tick();
    chk("midrst.stale1", {31'b0, lsu_done_o}, 32'd0);
    tick();
    chk("midrst.stale2", {31'b0, lsu_done_o}, 32'd0);
    chk("midrst.rdata2", lsu_rdata_o,         32'd0);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    tick();
    access("post_rst_lbu", 1'b0, 3'b100, 32'h00000301, 32'h0, 0, 0, 32'h00008000, 32'h00000300, 4'h2, 32'h0, 32'h00000080, 3);

`ifdef LSU_MISALIGN_TRAP_EN
    lsu_valid_i  = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_funct3_i = 3'b010;
    lsu_addr_i   = 32'h00000102;
    #1;
    chk("trap.stall", {31'b0, lsu_stall_o}, 32'd1);
    chk("trap.req0",  {31'b0, mem_req_o},   32'd0);
    tick();
    chk("trap.done",  {31'b0, lsu_done_o},     32'd1);
    chk("trap.mis",   {31'b0, lsu_misalign_o}, 32'd1);
    chk("trap.rdata", lsu_rdata_o,             32'd0);
    chk("trap.req1",  {31'b0, mem_req_o},      32'd0);
    lsu_valid_i = 1'b0;
    tick();
    chk("trap.req2",  {31'b0, mem_req_o},      32'd0);
    chk("trap.done2", {31'b0, lsu_done_o},     32'd0);
    chk("trap.mis2",  {31'b0, lsu_misalign_o}, 32'd0);
    tick();
`else
    access("lw_mis", 1'b0, 3'b010, 32'h00000102, 32'h0, 0, 0, 32'h89ABCDEF, 32'h00000100, 4'hF, 32'h0, 32'h89ABCDEF, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hang in the directed sequence.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
